// File: rtl/ttt_game_ctrl.sv
// ---------------------------------------------------------------------------
// ttt_game_ctrl
// Game-state engine for the 5x5 tic-tac-toe display, sitting upstream of vga.
// It owns the 25-cell board, the cursor and the player turn. It also performs
// mark placement, win detection over 5 rows, 5 columns and 2 diagonals, and
// draw detection.
//
// Ports
//   clk                 system clock (shared with vga)
//   reset               asynchronous, active-low reset
//   btn_up/down/left/right/place/new
//                       debounced, clk-synchronous button levels; the rising
//                       edge is the action
//   board1..board25     cell state, row-major (00 empty, 01 P1, 10 P2)
//   cursor              cursor cell index 0..24
//   turn                0 = P1 to move, 1 = P2 to move
//   place               one-cycle pulse when a mark is accepted
//   is_full             all cells occupied (combinational from the board)
//   playerwin           P1 has won (sticky until new game / reset)
//   player2win          P2 has won (sticky until new game / reset)
// ---------------------------------------------------------------------------
module ttt_game_ctrl #(
    parameter int START_CELL = 12,
    parameter bit WRAP       = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_place,
    input  logic       btn_new,
    output logic [1:0] board1,  board2,  board3,  board4,  board5,
    output logic [1:0] board6,  board7,  board8,  board9,  board10,
    output logic [1:0] board11, board12, board13, board14, board15,
    output logic [1:0] board16, board17, board18, board19, board20,
    output logic [1:0] board21, board22, board23, board24, board25,
    output logic [4:0] cursor,
    output logic       turn,
    output logic       place,
    output logic       is_full,
    output logic       playerwin,
    output logic       player2win
);

    typedef enum logic [1:0] {PLAY = 2'd0, CHECK = 2'd1, WIN = 2'd2, DRAW = 2'd3} state_t;

    // Read one 2-bit cell out of the packed board
    function automatic logic [1:0] cell_at(input logic [49:0] b, input logic [4:0] idx);
        return b[{idx, 1'b0} +: 2];
    endfunction

    // True when every cell holds a mark
    function automatic logic board_full(input logic [49:0] b);
        logic f;
        f = 1'b1;
        for (int k = 0; k < 25; k++) begin
            f &= (cell_at(b, 5'(k)) != 2'b00);
        end
        return f;
    endfunction

    // True when any row, column or full diagonal is five of 'mark'
    function automatic logic line_won(input logic [49:0] b, input logic [1:0] mark);
        logic won;
        logic hit_row, hit_col, hit_diag, hit_anti;
        won      = 1'b0;
        hit_diag = 1'b1;
        hit_anti = 1'b1;
        for (int i = 0; i < 5; i++) begin
            hit_row = 1'b1;
            hit_col = 1'b1;
            for (int j = 0; j < 5; j++) begin
                hit_row &= (cell_at(b, 5'(i * 5 + j)) == mark);
                hit_col &= (cell_at(b, 5'(j * 5 + i)) == mark);
            end
            won      |= hit_row | hit_col;
            hit_diag &= (cell_at(b, 5'(i * 6)) == mark);
            hit_anti &= (cell_at(b, 5'(4 + i * 4)) == mark);
        end
        return won | hit_diag | hit_anti;
    endfunction

    state_t      state_r;
    logic [49:0] cells_r;
    logic [4:0]  cursor_r;
    logic        turn_r, place_r, p1_win_r, p2_win_r;
    logic [5:0]  btn_q_r;
    logic        armed_r;

    logic [5:0]  btn_s, edge_s;
    logic [2:0]  row_s, col_s, next_row_s, next_col_s;
    logic [4:0]  next_cursor_s;
    logic [1:0]  mark_s;
    logic        full_s;

    // Button order: {new, place, right, left, down, up}
    assign btn_s = {btn_new, btn_place, btn_right, btn_left, btn_down, btn_up};
    // armed_r masks the first cycle after reset so a button held through
    // reset is seen as already high rather than as a fresh press
    assign edge_s = btn_s & ~btn_q_r & {6{armed_r}};

    assign row_s  = 3'(cursor_r / 5'd5);
    assign col_s  = 3'(cursor_r % 5'd5);
    assign mark_s = turn_r ? 2'b10 : 2'b01;
    assign full_s = board_full(cells_r);

    // Next cursor position for the highest-priority move edge
    always_comb begin
        next_row_s = row_s;
        next_col_s = col_s;
        if (edge_s[0]) begin
            next_row_s = (row_s == 3'd0) ? (WRAP ? 3'd4 : 3'd0) : row_s - 3'd1;
        end else if (edge_s[1]) begin
            next_row_s = (row_s == 3'd4) ? (WRAP ? 3'd0 : 3'd4) : row_s + 3'd1;
        end else if (edge_s[2]) begin
            next_col_s = (col_s == 3'd0) ? (WRAP ? 3'd4 : 3'd0) : col_s - 3'd1;
        end else if (edge_s[3]) begin
            next_col_s = (col_s == 3'd4) ? (WRAP ? 3'd0 : 3'd4) : col_s + 3'd1;
        end else begin
            next_row_s = row_s;
        end
        next_cursor_s = ({2'b00, next_row_s} * 5'd5) + {2'b00, next_col_s};
    end

    // Game FSM, board, cursor, turn, flags and button history
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= PLAY;
            cells_r  <= 50'd0;
            cursor_r <= 5'(START_CELL);
            turn_r   <= 1'b0;
            place_r  <= 1'b0;
            p1_win_r <= 1'b0;
            p2_win_r <= 1'b0;
            btn_q_r  <= 6'd0;
            armed_r  <= 1'b0;
        end else begin
            btn_q_r <= btn_s;
            armed_r <= 1'b1;
            place_r <= 1'b0;
            if (edge_s[5]) begin
                state_r  <= PLAY;
                cells_r  <= 50'd0;
                cursor_r <= 5'(START_CELL);
                turn_r   <= 1'b0;
                p1_win_r <= 1'b0;
                p2_win_r <= 1'b0;
            end else begin
                case (state_r)
                    PLAY: begin
                        if (edge_s[4]) begin
                            // Occupied cell: the press is simply consumed
                            if (cell_at(cells_r, cursor_r) == 2'b00) begin
                                cells_r[{cursor_r, 1'b0} +: 2] <= mark_s;
                                place_r <= 1'b1;
                                state_r <= CHECK;
                            end
                        end else if (|edge_s[3:0]) begin
                            cursor_r <= next_cursor_s;
                        end
                    end
                    CHECK: begin
                        // Only the mover can have just completed a line
                        if (line_won(cells_r, mark_s)) begin
                            p1_win_r <= ~turn_r;
                            p2_win_r <= turn_r;
                            state_r  <= WIN;
                        end else if (full_s) begin
                            state_r <= DRAW;
                        end else begin
                            turn_r  <= ~turn_r;
                            state_r <= PLAY;
                        end
                    end
                    WIN, DRAW: begin
                        state_r <= state_r;
                    end
                    default: begin
                        state_r <= PLAY;
                    end
                endcase
            end
        end
    end

    assign cursor     = cursor_r;
    assign turn       = turn_r;
    assign place      = place_r;
    assign is_full    = full_s;
    assign playerwin  = p1_win_r;
    assign player2win = p2_win_r;

    assign board1  = cells_r[1:0];   assign board2  = cells_r[3:2];
    assign board3  = cells_r[5:4];   assign board4  = cells_r[7:6];
    assign board5  = cells_r[9:8];   assign board6  = cells_r[11:10];
    assign board7  = cells_r[13:12]; assign board8  = cells_r[15:14];
    assign board9  = cells_r[17:16]; assign board10 = cells_r[19:18];
    assign board11 = cells_r[21:20]; assign board12 = cells_r[23:22];
    assign board13 = cells_r[25:24]; assign board14 = cells_r[27:26];
    assign board15 = cells_r[29:28]; assign board16 = cells_r[31:30];
    assign board17 = cells_r[33:32]; assign board18 = cells_r[35:34];
    assign board19 = cells_r[37:36]; assign board20 = cells_r[39:38];
    assign board21 = cells_r[41:40]; assign board22 = cells_r[43:42];
    assign board23 = cells_r[45:44]; assign board24 = cells_r[47:46];
    assign board25 = cells_r[49:48];

endmodule
